// File: rtl/hub75_scan_ctrl.sv
// rtl/hub75_scan_ctrl.sv - HUB75 1/2^ROW_BITS scan sequencer with BCM colour planes
// Fetches a row from the frame buffer per plane, shifts it out, then latches and displays it.
module hub75_scan_ctrl #(
    parameter int COL_BITS  = 6,
    parameter int ROW_BITS  = 4,
    parameter int BITS      = 4,
    parameter int CLK_DIV   = 2,
    parameter int BLANK_CYC = 4,
    parameter int OE_BASE   = 64
) (
    input  logic                         CLK_100MHz,
    input  logic                         RST,
    input  logic                         ENABLE,
    output logic                         FB_RD,
    output logic [ROW_BITS+COL_BITS-1:0] FB_ADDR,
    input  logic [6*BITS-1:0]            FB_DATA,
    output logic                         R1,
    output logic                         G1,
    output logic                         B1,
    output logic                         R2,
    output logic                         G2,
    output logic                         B2,
    output logic                         LED_CLK,
    output logic                         LED_LATCH,
    output logic                         LED_OE,
    output logic [ROW_BITS-1:0]          DMUX,
    output logic                         FRAME_DONE,
    output logic                         BUSY
);

    localparam int COLS    = 1 << COL_BITS;
    localparam int PB      = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int OE_MAX  = OE_BASE << (BITS - 1);
    localparam int CNT_M1  = (OE_MAX > BLANK_CYC) ? OE_MAX : BLANK_CYC;
    localparam int CNT_MAX = (CNT_M1 > 2 * CLK_DIV) ? CNT_M1 : 2 * CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRE     = 3'd1;
    localparam logic [2:0] S_SHIFT   = 3'd2;
    localparam logic [2:0] S_BLANK   = 3'd3;
    localparam logic [2:0] S_LATCH   = 3'd4;
    localparam logic [2:0] S_DISPLAY = 3'd5;

    logic [2:0]                   state_q, state_d;
    logic [ROW_BITS-1:0]          row_q, row_d;
    logic [PB-1:0]                plane_q, plane_d;
    logic [COL_BITS-1:0]          col_q, col_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [5:0]                   rgb_q, rgb_d;
    logic [5:0]                   hold_q, hold_d;
    logic [ROW_BITS+COL_BITS-1:0] addr_q, addr_d;
    logic [ROW_BITS-1:0]          dmux_q, dmux_d;
    logic                         fb_rd;
    logic                         frame_done;
    logic [5:0]                   pix_bits;
    logic [BITS-1:0]              field;
    logic [CNT_W-1:0]             oe_last;

    // pix_bits[5] is R1 ... pix_bits[0] is B2, each the current plane's bit of its field
    always_comb begin
        pix_bits = '0;
        field    = '0;
        for (int k = 0; k < 6; k++) begin
            field       = FB_DATA[k*BITS +: BITS];
            pix_bits[k] = field[plane_q];
        end
    end

    assign oe_last = CNT_W'((OE_BASE << plane_q) - 1);

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        plane_d    = plane_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        rgb_d      = rgb_q;
        hold_d     = hold_q;
        addr_d     = addr_q;
        dmux_d     = dmux_q;
        fb_rd      = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ENABLE) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                end
            end
            S_PRE: begin
                if (cnt_q == '0) begin
                    fb_rd  = 1'b1;
                    addr_d = {row_q, COL_BITS'(0)};
                    cnt_d  = CNT_W'(1);
                end else begin
                    rgb_d   = pix_bits;
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    col_d   = '0;
                end
            end
            S_SHIFT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Prefetch the next column while the current one is being clocked out
                if (cnt_q == '0 && col_q != '1) begin
                    fb_rd  = 1'b1;
                    addr_d = {row_q, col_q + COL_BITS'(1)};
                end
                if (cnt_q == CNT_W'(1) && col_q != '1) begin
                    hold_d = pix_bits;
                end
                if (cnt_q == CNT_W'(2 * CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (col_q == '1) begin
                        state_d = S_BLANK;
                        dmux_d  = row_q;
                    end else begin
                        col_d = col_q + COL_BITS'(1);
                        rgb_d = hold_q;
                    end
                end
            end
            S_BLANK: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
                    state_d = S_LATCH;
                    cnt_d   = '0;
                end
            end
            S_LATCH: begin
                state_d = S_DISPLAY;
                cnt_d   = '0;
            end
            S_DISPLAY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == oe_last) begin
                    cnt_d = '0;
                    if (plane_q == PB'(BITS - 1)) begin
                        plane_d    = '0;
                        row_d      = row_q + ROW_BITS'(1);
                        frame_done = &row_q;
                    end else begin
                        plane_d = plane_q + PB'(1);
                    end
                    state_d = ENABLE ? S_PRE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_100MHz) begin
        if (RST) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            plane_q <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            rgb_q   <= '0;
            hold_q  <= '0;
            addr_q  <= '0;
            dmux_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            plane_q <= plane_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            rgb_q   <= rgb_d;
            hold_q  <= hold_d;
            addr_q  <= addr_d;
            dmux_q  <= dmux_d;
        end
    end

    assign FB_RD      = fb_rd;
    assign FB_ADDR    = addr_d;
    assign {R1, G1, B1, R2, G2, B2} = rgb_q;
    assign LED_CLK    = (state_q == S_SHIFT) && (cnt_q >= CNT_W'(CLK_DIV));
    assign LED_LATCH  = (state_q == S_LATCH);
    assign LED_OE     = (state_q != S_DISPLAY);
    assign DMUX       = dmux_q;
    assign FRAME_DONE = frame_done;
    assign BUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb/tb_hub75_scan_ctrl.sv - directed scoreboard bench for hub75_scan_ctrl
module tb_hub75_scan_ctrl;

    localparam int COL_BITS  = 6;
    localparam int ROW_BITS  = 4;
    localparam int BITS      = 4;
    localparam int CLK_DIV   = 2;
    localparam int BLANK_CYC = 4;
    localparam int OE_BASE   = 64;
    localparam int COLS      = 1 << COL_BITS;
    localparam int OVERHEAD  = 2 + COLS * 2 * CLK_DIV + BLANK_CYC + 1;
    localparam logic [63:0] RST_VEC = 64'h40;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic                         enable = 1'b0;
    logic                         fb_rd;
    logic [ROW_BITS+COL_BITS-1:0] fb_addr;
    logic [6*BITS-1:0]            fb_data = '0;
    logic                         r1, g1, b1, r2, g2, b2;
    logic                         led_clk, led_latch, led_oe;
    logic [ROW_BITS-1:0]          dmux;
    logic                         frame_done, busy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [ROW_BITS+COL_BITS-1:0] exp_addr[$];
    logic [5:0]                   exp_pix[$];

    hub75_scan_ctrl dut (
        .CLK_100MHz(clk),
        .RST(rst),
        .ENABLE(enable),
        .FB_RD(fb_rd),
        .FB_ADDR(fb_addr),
        .FB_DATA(fb_data),
        .R1(r1),
        .G1(g1),
        .B1(b1),
        .R2(r2),
        .G2(g2),
        .B2(b2),
        .LED_CLK(led_clk),
        .LED_LATCH(led_latch),
        .LED_OE(led_oe),
        .DMUX(dmux),
        .FRAME_DONE(frame_done),
        .BUSY(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] mem_f(input int a);
        logic [31:0] h;
        h = 32'(a) * 32'h9E3779B1;
        h = h ^ (h >> 13);
        return h[23:0];
    endfunction

    function automatic logic [5:0] exp_bits(input int a, input int p);
        logic [23:0] d;
        logic [23:0] t;
        logic [5:0]  b;
        d = mem_f(a);
        for (int k = 0; k < 6; k++) begin
            t    = d >> (k * BITS + p);
            b[k] = t[0];
        end
        return b;
    endfunction

    // Frame-buffer model with one cycle of read latency
    always_ff @(posedge clk) begin
        if (fb_rd) fb_data <= mem_f(int'(fb_addr));
    end

    function automatic logic [63:0] out_vec();
        return {38'd0, fb_rd, fb_addr, r1, g1, b1, r2, g2, b2,
                led_clk, led_latch, led_oe, dmux, frame_done, busy};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_plane(input int r, input int p, input bit drop, output int cyc);
        int       rd_n, rise_n, latch_n, oe_n, fd_n, last_hi, latch_at, dmux_bad, fd_last, width, exp_fd;
        logic     prev_clk;
        logic [5:0] ep;
        logic [ROW_BITS+COL_BITS-1:0] ea;
        width = OE_BASE << p;
        exp_fd = (r == (1 << ROW_BITS) - 1 && p == BITS - 1) ? 1 : 0;
        exp_addr.delete();
        exp_pix.delete();
        for (int c = 0; c < COLS; c++) begin
            exp_addr.push_back((ROW_BITS + COL_BITS)'(r * COLS + c));
            exp_pix.push_back(exp_bits(r * COLS + c, p));
        end
        cyc = 0; rd_n = 0; rise_n = 0; latch_n = 0; oe_n = 0; fd_n = 0;
        last_hi = -100; latch_at = -1; dmux_bad = 0; fd_last = 0;
        prev_clk = 1'b0;
        while (oe_n < width && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (fb_rd) begin
                rd_n++;
                if (exp_addr.size() == 0) check("extra_fb_rd", 64'(rd_n), 64'(COLS));
                else begin
                    ea = exp_addr.pop_front();
                    check("fb_addr", 64'(fb_addr), 64'(ea));
                end
            end
            if (led_clk && !prev_clk) begin
                rise_n++;
                if (exp_pix.size() == 0) check("extra_led_clk", 64'(rise_n), 64'(COLS));
                else begin
                    ep = exp_pix.pop_front();
                    check("pixel", 64'({r1, g1, b1, r2, g2, b2}), 64'(ep));
                end
            end
            if (led_clk) last_hi = cyc;
            prev_clk = led_clk;
            if (led_latch) begin
                latch_n++;
                latch_at = cyc;
            end
            if (!led_oe) begin
                oe_n++;
                if (int'(dmux) != r) dmux_bad++;
                if (frame_done) fd_last = (oe_n == width) ? 1 : 0;
            end
            if (frame_done) fd_n++;
            if (drop && rise_n == 10 && enable) enable = 1'b0;
        end
        check("plane_cycles", 64'(cyc), 64'(OVERHEAD + width));
        check("fb_rd_count", 64'(rd_n), 64'(COLS));
        check("led_clk_rises", 64'(rise_n), 64'(COLS));
        check("latch_count", 64'(latch_n), 64'd1);
        check("latch_after_clk", 64'(latch_at - last_hi), 64'(BLANK_CYC + 1));
        check("latch_before_oe", 64'(latch_at), 64'(cyc - width));
        check("oe_width", 64'(oe_n), 64'(width));
        check("dmux_in_display", 64'(dmux_bad), 64'd0);
        check("frame_done_count", 64'(fd_n), 64'(exp_fd));
        check("frame_done_last", 64'(fd_last), 64'(exp_fd));
    endtask

    initial begin
        int c;
        int total;
        int n;
        bit oe_seen;

        rst = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), RST_VEC);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_outputs", out_vec(), RST_VEC);
        end

        // First plane, full row of BCM weights, then the rest of the frame
        enable = 1'b1;
        total = 0;
        for (int r = 0; r < (1 << ROW_BITS); r++) begin
            for (int p = 0; p < BITS; p++) begin
                run_plane(r, p, 1'b0, c);
                total += c;
            end
        end
        check("frame_cycles", 64'(total), 64'd32192);

        // Wrap back to row 0 and advance to row 2 plane 1
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < BITS; p++) begin
                if (r == 2 && p == 1) break;
                run_plane(r, p, 1'b0, c);
            end
        end

        run_plane(2, 1, 1'b1, c);
        @(negedge clk);
        check("drop_busy", 64'(busy), 64'd0);
        check("drop_oe", 64'(led_oe), 64'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("drop_idle", out_vec() & 64'h0200_0001, 64'd0);
        end
        enable = 1'b1;
        run_plane(2, 2, 1'b0, c);
        run_plane(2, 3, 1'b0, c);

        for (int r = 3; r < 8; r++) begin
            for (int p = 0; p < BITS; p++) begin
                if (r == 7 && p == 3) break;
                run_plane(r, p, 1'b0, c);
            end
        end

        oe_seen = 1'b0;
        n = 0;
        while (!oe_seen && n < 1000) begin
            @(negedge clk);
            n++;
            if (!led_oe) oe_seen = 1'b1;
        end
        check("row7_oe_reached", 64'(oe_seen), 64'd1);
        repeat (50) @(negedge clk);
        check("row7_dmux", 64'(dmux), 64'd7);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_display", out_vec(), RST_VEC);
        rst = 1'b0;
        run_plane(0, 0, 1'b0, c);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
